entrada_botoes: RTL and testbench

//  Conditions the 9 raw board buttons before they reach the game datapath.
//  - Debounces the buttons.
//  - Accepts exactly one press per push-release cycle and encodes it (index 0-8 plus one-hot).
//  - Holds tem_jogada until the control unit clears it with zeraEdge.

---
 rtl/entrada_botoes_pkg.sv | 24 ++
 rtl/entrada_botoes_if.sv | 19 +
 rtl/entrada_botoes_filtro_botoes.sv | 46 ++++
 rtl/entrada_botoes.sv | 61 ++++++
 tb/tb_entrada_botoes.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/entrada_botoes_pkg.sv
// entrada_botoes_pkg: shared cell/position widths, FSM state codes and press encoders.
package entrada_botoes_pkg;
    localparam int NUM_CELULAS = 9;
    localparam int POS_W = 4;
    localparam logic [1:0] SOLTAR = 2'd0;
    localparam logic [1:0] ESPERA = 2'd1;
    localparam logic [1:0] CAPTURA = 2'd2;
    typedef logic [NUM_CELULAS-1:0] botoes_t;
    typedef logic [POS_W-1:0] posicao_t;

    function automatic logic [3:0] popcount(input botoes_t v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_CELULAS; i++) c = c + {3'b0, v[i]};
        return c;
    endfunction

    function automatic posicao_t encode(input botoes_t v);
        posicao_t p;
        p = '0;
        for (int i = 0; i < NUM_CELULAS; i++) if (v[i]) p = POS_W'(i);
        return p;
    endfunction
endpackage

// File: rtl/entrada_botoes_if.sv
// entrada_botoes_if: button inputs and registered-press outputs between board, conditioner and control unit.
interface entrada_botoes_if;
    import entrada_botoes_pkg::*;
    botoes_t botoes;
    logic zeraEdge;
    logic tem_jogada;
    posicao_t posicao;
    botoes_t jogada_onehot;
    logic erro_multi;
    logic [1:0] db_estado;
    modport master (
        output botoes, zeraEdge,
        input tem_jogada, posicao, jogada_onehot, erro_multi, db_estado
    );
    modport slave (
        input botoes, zeraEdge,
        output tem_jogada, posicao, jogada_onehot, erro_multi, db_estado
    );
endinterface

// File: rtl/entrada_botoes_filtro_botoes.sv
// entrada_botoes_filtro_botoes: debounce filter; ENTRADA_SYNC_EN adds a 2-flop synchronizer ahead of raw_q.
module entrada_botoes_filtro_botoes
    import entrada_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic    clock,
    input  logic    reset,
    input  botoes_t botoes,
    output botoes_t estavel,
    output logic    stb
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] PRE = CW'(DEBOUNCE_CICLOS - 2);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CICLOS - 1);
    botoes_t src, raw_q;
    logic [CW-1:0] cnt;
`ifdef ENTRADA_SYNC_EN
    botoes_t s1, s2;
    always_ff @(posedge clock) begin
        s1 <= reset ? '0 : botoes;
        s2 <= reset ? '0 : s1;
    end
    assign src = s2;
`else
    assign src = botoes;
`endif
    // stb fires only on the PRE->LAST step, so once per plateau
    always_ff @(posedge clock) begin
        if (reset) begin
            raw_q <= '0;
            cnt <= '0;
            estavel <= '1;
            stb <= 1'b0;
        end else begin
            raw_q <= src;
            stb <= 1'b0;
            if (src != raw_q) cnt <= '0;
            else if (cnt == PRE) begin
                cnt <= LAST;
                estavel <= raw_q;
                stb <= 1'b1;
            end else cnt <= (cnt == LAST) ? cnt : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/entrada_botoes.sv
// entrada_botoes: debounces the 9 buttons and registers one encoded press per push-release cycle.
module entrada_botoes
    import entrada_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input logic clock,
    input logic reset,
    entrada_botoes_if.slave bus
);
    botoes_t estavel, onehot;
    logic stb, multi, tem_jogada, erro_multi;
    logic [1:0] estado, prox;
    posicao_t posicao;
    logic [3:0] pc;

    entrada_botoes_filtro_botoes #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_filtro (
        .clock(clock),
        .reset(reset),
        .botoes(bus.botoes),
        .estavel(estavel),
        .stb(stb)
    );

    always_comb begin
        pc = popcount(estavel);
        multi = stb && estado == ESPERA && pc > 4'd1;
        prox = estado == SOLTAR ? ((stb && estavel == '0) ? ESPERA : SOLTAR)
             : estado == ESPERA ? ((stb && pc == 4'd1) ? CAPTURA : multi ? SOLTAR : ESPERA)
             : SOLTAR;
    end

    // a capture in the same cycle as zeraEdge takes priority over the clear
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= SOLTAR;
            tem_jogada <= 1'b0;
            posicao <= '0;
            onehot <= '0;
            erro_multi <= 1'b0;
        end else begin
            estado <= prox;
            erro_multi <= multi;
            if (estado == CAPTURA && !tem_jogada) begin
                tem_jogada <= 1'b1;
                posicao <= encode(estavel);
                onehot <= estavel;
            end else if (bus.zeraEdge) begin
                tem_jogada <= 1'b0;
                posicao <= '0;
                onehot <= '0;
            end
        end
    end

    assign bus.tem_jogada = tem_jogada;
    assign bus.posicao = posicao;
    assign bus.jogada_onehot = onehot;
    assign bus.erro_multi = erro_multi;
    assign bus.db_estado = estado;
endmodule

// File: tb/tb_entrada_botoes.sv
// tb_entrada_botoes: table-driven check of entrada_botoes with DEBOUNCE_CICLOS=4 (ENTRADA_SYNC_EN shifts timing by 2).
module tb_entrada_botoes;
`ifdef ENTRADA_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif
    typedef struct {
        logic rst;
        logic [8:0] b;
        logic z;
        int n;
        logic tem;
        logic [3:0] pos;
        logic [8:0] oh;
        logic erro;
        logic [1:0] est;
        string nome;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int tests = 0;
    int fails = 0;
    vec_t v[$];

    entrada_botoes_if bus();
    entrada_botoes #(.DEBOUNCE_CICLOS(4)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nome, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [8:0] b, input logic z, input int n,
                       input logic tem, input logic [3:0] pos, input logic [8:0] oh,
                       input logic erro, input logic [1:0] est, input string nome);
        vec_t e;
        e.rst = rst; e.b = b; e.z = z; e.n = n;
        e.tem = tem; e.pos = pos; e.oh = oh; e.erro = erro; e.est = est; e.nome = nome;
        v.push_back(e);
    endtask

    task automatic chk_all(input string nome, input logic tem, input logic [3:0] pos,
                           input logic [8:0] oh, input logic erro, input logic [1:0] est);
        chk({nome, ".tem_jogada"}, {8'b0, bus.tem_jogada}, {8'b0, tem});
        chk({nome, ".posicao"}, {5'b0, bus.posicao}, {5'b0, pos});
        chk({nome, ".onehot"}, bus.jogada_onehot, oh);
        chk({nome, ".erro_multi"}, {8'b0, bus.erro_multi}, {8'b0, erro});
        chk({nome, ".db_estado"}, {7'b0, bus.db_estado}, {7'b0, est});
    endtask

    initial begin
        int n_erro;
        reset = 1'b1;
        bus.botoes = '0;
        bus.zeraEdge = 1'b0;
        add(1, 9'h000, 0, 2,     0, 0, 9'h000, 0, 0, "reset");
        add(0, 9'h000, 0, 4,     0, 0, 9'h000, 0, 1, "plateau0");
        add(0, 9'h010, 0, 5+S,   0, 0, 9'h000, 0, 2, "t1_captura");
        add(0, 9'h010, 0, 1,     1, 4, 9'h010, 0, 0, "t1_jogada");
        add(0, 9'h010, 0, 4,     1, 4, 9'h010, 0, 0, "t1_segura");
        add(0, 9'h000, 1, 1,     0, 0, 9'h000, 0, 0, "t1_zera");
        add(0, 9'h000, 0, 4+S,   0, 0, 9'h000, 0, 1, "t1_solta");
        add(0, 9'h003, 0, 4+S,   0, 0, 9'h000, 0, 1, "t3_multi_stb");
        add(0, 9'h003, 0, 1,     0, 0, 9'h000, 1, 0, "t3_erro");
        add(0, 9'h003, 0, 1,     0, 0, 9'h000, 0, 0, "t3_erro_fim");
        add(0, 9'h000, 0, 5+S,   0, 0, 9'h000, 0, 1, "t3_solta");
        add(0, 9'h100, 0, 6+S,   1, 8, 9'h100, 0, 0, "t3_pos8");
        add(0, 9'h000, 1, 1,     0, 0, 9'h000, 0, 0, "t4_zera");
        add(0, 9'h000, 0, 4+S,   0, 0, 9'h000, 0, 1, "t4_solta");
        add(0, 9'h004, 0, 6+S,   1, 2, 9'h004, 0, 0, "t4_pos2");
        add(0, 9'h000, 0, 5+S,   1, 2, 9'h004, 0, 1, "t4_solta2");
        add(0, 9'h040, 0, 5+S,   1, 2, 9'h004, 0, 2, "t4_captura2");
        add(0, 9'h040, 0, 1,     1, 2, 9'h004, 0, 0, "t4_descarta");
        add(0, 9'h040, 1, 1,     0, 0, 9'h000, 0, 0, "t4_zera2");
        add(0, 9'h000, 0, 5+S,   0, 0, 9'h000, 0, 1, "col_solta");
        add(0, 9'h080, 0, 5+S,   0, 0, 9'h000, 0, 2, "col_captura");
        add(0, 9'h080, 1, 1,     1, 7, 9'h080, 0, 0, "col_captura_ganha");
        add(0, 9'h080, 1, 1,     0, 0, 9'h000, 0, 0, "col_zera");
        add(1, 9'h020, 0, 2,     0, 0, 9'h000, 0, 0, "t5_reset");
        add(0, 9'h020, 0, 8,     0, 0, 9'h000, 0, 0, "t5_segura");
        add(0, 9'h000, 0, 5+S,   0, 0, 9'h000, 0, 1, "t5_solta");
        add(0, 9'h020, 0, 6+S,   1, 5, 9'h020, 0, 0, "t5_pos5");
        add(0, 9'h020, 1, 1,     0, 0, 9'h000, 0, 0, "rd_zera");
        add(0, 9'h000, 0, 5+S,   0, 0, 9'h000, 0, 1, "rd_solta");
        add(0, 9'h010, 0, 2+S,   0, 0, 9'h000, 0, 1, "rd_meio");
        add(1, 9'h010, 0, 1,     0, 0, 9'h000, 0, 0, "rd_reset");
        add(0, 9'h010, 0, 8,     0, 0, 9'h000, 0, 0, "rd_sem_captura");
        add(0, 9'h000, 0, 5+S,   0, 0, 9'h000, 0, 1, "rc_solta");
        add(0, 9'h001, 0, 5+S,   0, 0, 9'h000, 0, 2, "rc_captura");
        add(1, 9'h001, 0, 1,     0, 0, 9'h000, 0, 0, "rc_reset");
        add(0, 9'h000, 0, 4,     0, 0, 9'h000, 0, 1, "rc_sem_captura");
        foreach (v[k]) begin
            reset = v[k].rst;
            bus.botoes = v[k].b;
            bus.zeraEdge = v[k].z;
            repeat (v[k].n) tick();
            chk_all(v[k].nome, v[k].tem, v[k].pos, v[k].oh, v[k].erro, v[k].est);
        end
        bus.zeraEdge = 1'b0;
        // glitches shorter than the window never form a plateau
        for (int i = 0; i < 10; i++) begin
            bus.botoes = (i % 2 == 0) ? 9'h001 : 9'h000;
            repeat (2) tick();
            chk("bounce.tem_jogada", {8'b0, bus.tem_jogada}, 9'h000);
            chk("bounce.db_estado", {7'b0, bus.db_estado}, 9'h001);
        end
        bus.botoes = 9'h000;
        repeat (6) tick();
        chk("bounce_fim.db_estado", {7'b0, bus.db_estado}, 9'h001);
        bus.botoes = 9'h003;
        n_erro = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_erro += int'(bus.erro_multi);
        end
        chk("multi.pulsos", 9'(n_erro), 9'd1);
        chk("multi.tem_jogada", {8'b0, bus.tem_jogada}, 9'h000);
        bus.botoes = 9'h000;
        repeat (5+S) tick();
        bus.botoes = 9'h100;
        repeat (6+S) tick();
        chk_all("seq_pos8", 1, 8, 9'h100, 0, 0);
        bus.botoes = 9'h180;
        n_erro = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_erro += int'(bus.erro_multi);
        end
        chk("segundo_botao.pulsos", 9'(n_erro), 9'd0);
        chk_all("segundo_botao", 1, 8, 9'h100, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
